// File: rtl/ide_pio_engine.sv
// ide_pio_engine: clocked PIO timing engine for up to two IDE channels in the autoconfigured IDE window
// Ports:
//   CLK, RESET_n          7 MHz bus clock, asynchronous active-low reset
//   ADDR[23:1]            bus address; [15:14] region (ROM/ch0/ch1/control), [12] CS1/CS2, [2] control channel
//   AS_n, UDS_n, LDS_n, RW  bus strobes and direction
//   DIN[3:0]              DBUS[15:12] write data for the control region
//   ide_access            window match from Autoconfig
//   ide_enable            IDE drives enabled
//   DTACK                 active-high acknowledge
//   IOR_n, IOW_n          IDE read/write strobes
//   IDECS1_n, IDECS2_n    per-channel chip selects
//   IDE_ROMEN             boot ROM enable
//   DOUT, DOUT_OE         control-register read data and its output enable
// Build option: define IDE_PIO_TIMING_REG_EN for writable per-channel strobe widths;
// otherwise the width is fixed at STROBE_DEF and control writes are ignored.
module ide_pio_engine #(
   parameter int CHANNELS    = 2,
   parameter int CNT_W       = 4,
   parameter int SETUP_CYC   = 1,
   parameter int STROBE_DEF  = 3,
   parameter int HOLD_CYC    = 1,
   parameter int RECOVER_CYC = 2,
   parameter int ROM_WAIT    = 2
)(
   input  logic                CLK,
   input  logic                RESET_n,
   input  logic [23:1]         ADDR,
   input  logic                AS_n,
   input  logic                UDS_n,
   input  logic                LDS_n,
   input  logic                RW,
   input  logic [3:0]          DIN,
   input  logic                ide_access,
   input  logic                ide_enable,
   output logic                DTACK,
   output logic                IOR_n,
   output logic                IOW_n,
   output logic [CHANNELS-1:0] IDECS1_n,
   output logic [CHANNELS-1:0] IDECS2_n,
   output logic                IDE_ROMEN,
   output logic [3:0]          DOUT,
   output logic                DOUT_OE
);
   // counters hold N-1; zero-valued timing parameters behave as one clock
   localparam logic [CNT_W-1:0] SET_L = CNT_W'((SETUP_CYC < 1 ? 1 : SETUP_CYC) - 1);
   localparam logic [CNT_W-1:0] HLD_L = CNT_W'((HOLD_CYC < 1 ? 1 : HOLD_CYC) - 1);
   localparam logic [CNT_W-1:0] REC_L = CNT_W'((RECOVER_CYC < 1 ? 1 : RECOVER_CYC) - 1);
   localparam logic [CNT_W-1:0] ROM_L = CNT_W'((ROM_WAIT < 1 ? 1 : ROM_WAIT) - 1);
   localparam logic [CNT_W-1:0] STR_D = CNT_W'(STROBE_DEF < 1 ? 1 : STROBE_DEF);
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK, RECOVER} state_t;
   state_t              state;
   logic [CNT_W-1:0]    cnt, cur_w, ctl_w;
   logic                ch_q, live_q, rw_q;
   logic                start, a_live, a_ctl;
   logic [CHANNELS-1:0] ch_mask;
   logic                unused_bits;
   assign start   = state == IDLE && !AS_n && ide_access && (!UDS_n || !LDS_n);
   // only a real, enabled, existing channel gets CS and strobes; anything else is a null cycle
   assign a_live  = ^ADDR[15:14] && ide_enable && (!ADDR[15] || CHANNELS > 1);
   assign a_ctl   = &ADDR[15:14];
   assign ch_mask = CHANNELS'(1) << ADDR[15];
`ifdef IDE_PIO_TIMING_REG_EN
   logic [CNT_W-1:0] str0, str1, din_w;
   assign din_w = DIN == 4'd0 ? CNT_W'(1) : CNT_W'(DIN);
   assign cur_w = ch_q ? str1 : str0;
   assign ctl_w = ADDR[2] ? str1 : str0;
   assign unused_bits = &{1'b0, ADDR[23:16], ADDR[13], ADDR[11:3], ADDR[1]};
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         str0 <= STR_D;
         str1 <= STR_D;
      end else if (start && a_ctl && !RW) begin
         if (ADDR[2]) str1 <= din_w;
         else str0 <= din_w;
      end
   end
`else
   assign cur_w = STR_D;
   assign ctl_w = STR_D;
   assign unused_bits = &{1'b0, ADDR[23:16], ADDR[13], ADDR[11:1], DIN, ch_q};
`endif
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state     <= IDLE;
         cnt       <= '0;
         ch_q      <= 1'b0;
         live_q    <= 1'b0;
         rw_q      <= 1'b0;
         DTACK     <= 1'b0;
         IOR_n     <= 1'b1;
         IOW_n     <= 1'b1;
         IDECS1_n  <= '1;
         IDECS2_n  <= '1;
         IDE_ROMEN <= 1'b0;
         DOUT      <= '0;
         DOUT_OE   <= 1'b0;
      end else if (state != IDLE && state != RECOVER && AS_n) begin
         // normal end of ACK and abort in SETUP/STROBE/HOLD share the same release
         state     <= RECOVER;
         cnt       <= REC_L;
         DTACK     <= 1'b0;
         IOR_n     <= 1'b1;
         IOW_n     <= 1'b1;
         IDECS1_n  <= '1;
         IDECS2_n  <= '1;
         IDE_ROMEN <= 1'b0;
         DOUT      <= '0;
         DOUT_OE   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state  <= SETUP;
               ch_q   <= ADDR[15];
               live_q <= a_live;
               rw_q   <= RW;
               cnt    <= a_live ? SET_L : ADDR[15:14] == 2'b00 ? ROM_L : '0;
               if (a_live) begin
                  IDECS1_n <= ADDR[12] ? '1 : ~ch_mask;
                  IDECS2_n <= ADDR[12] ? ~ch_mask : '1;
               end
               if (ADDR[15:14] == 2'b00) IDE_ROMEN <= 1'b1;
               if (a_ctl && RW) begin
                  DOUT    <= 4'(ctl_w);
                  DOUT_OE <= 1'b1;
               end
            end
            // SETUP doubles as the wait state for ROM, control and null cycles
            SETUP: if (cnt != '0) cnt <= cnt - 1'b1;
               else if (live_q) begin
                  state <= STROBE;
                  cnt   <= cur_w - 1'b1;
                  IOR_n <= !rw_q;
                  IOW_n <= rw_q;
               end else begin
                  state <= ACK;
                  DTACK <= 1'b1;
               end
            STROBE: if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  state <= HOLD;
                  cnt   <= HLD_L;
                  IOR_n <= 1'b1;
                  IOW_n <= 1'b1;
               end
            HOLD: if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  state <= ACK;
                  DTACK <= 1'b1;
               end
            RECOVER: if (cnt != '0) cnt <= cnt - 1'b1;
               else state <= IDLE;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ide_pio_engine.sv
// tb_ide_pio_engine: table-driven and hand-sequenced checks of the IDE PIO timing engine
module tb_ide_pio_engine;
`ifdef IDE_PIO_TIMING_REG_EN
   localparam int W6 = 6;
   localparam int W0 = 1;
`else
   localparam int W6 = 3;
   localparam int W0 = 3;
`endif
   typedef struct {
      logic [23:0] a;
      logic        rw;
      logic [3:0]  din;
      logic        en;
      int          ior_w;
      int          iow_w;
      logic [1:0]  cs1;
      logic [1:0]  cs2;
      logic        rom;
      int          lat;
      logic        doe;
      int          dout;
   } vec_t;
   logic        CLK = 0, RESET_n = 0;
   logic [23:1] ADDR = '0;
   logic        AS_n = 1, UDS_n = 1, LDS_n = 1, RW = 1;
   logic [3:0]  DIN = '0;
   logic        ide_access = 1, ide_enable = 1;
   logic        d0, ior0, iow0, rom0, doe0;
   logic [1:0]  c10, c20;
   logic [3:0]  dout0;
   logic        d1, ior1, iow1, rom1, doe1, c11, c21;
   logic [3:0]  dout1;
   logic        mon = 0;
   logic        m_dtack, m_ior, m_iow, m_rom, m_doe;
   logic [1:0]  m_cs1, m_cs2;
   logic [3:0]  m_dout;
   int          checks = 0, errors = 0;
   vec_t        vt[12];
   int          n;
   ide_pio_engine u0 (
      .CLK(CLK), .RESET_n(RESET_n), .ADDR(ADDR), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
      .DIN(DIN), .ide_access(ide_access), .ide_enable(ide_enable), .DTACK(d0), .IOR_n(ior0), .IOW_n(iow0),
      .IDECS1_n(c10), .IDECS2_n(c20), .IDE_ROMEN(rom0), .DOUT(dout0), .DOUT_OE(doe0));
   ide_pio_engine #(.CHANNELS(1)) u1 (
      .CLK(CLK), .RESET_n(RESET_n), .ADDR(ADDR), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW(RW),
      .DIN(DIN), .ide_access(ide_access), .ide_enable(ide_enable), .DTACK(d1), .IOR_n(ior1), .IOW_n(iow1),
      .IDECS1_n(c11), .IDECS2_n(c21), .IDE_ROMEN(rom1), .DOUT(dout1), .DOUT_OE(doe1));
   assign m_dtack = mon ? d1 : d0;
   assign m_ior   = mon ? ior1 : ior0;
   assign m_iow   = mon ? iow1 : iow0;
   assign m_rom   = mon ? rom1 : rom0;
   assign m_doe   = mon ? doe1 : doe0;
   assign m_dout  = mon ? dout1 : dout0;
   assign m_cs1   = mon ? {1'b1, c11} : c10;
   assign m_cs2   = mon ? {1'b1, c21} : c20;
   always #5 CLK = ~CLK;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic drive(input logic [23:0] a, input logic rw, input logic [3:0] din);
      ADDR = a[23:1];
      RW = rw;
      DIN = din;
      UDS_n = 0;
      LDS_n = 0;
      AS_n = 0;
   endtask
   task automatic release_bus();
      AS_n = 1;
      UDS_n = 1;
      LDS_n = 1;
   endtask
   task automatic wait_dtack(output int cnt);
      cnt = 0;
      for (int i = 1; i <= 40 && cnt == 0; i++) begin
         @(negedge CLK);
         if (m_dtack) cnt = i;
      end
   endtask
   task automatic wait_cs(output int cnt);
      cnt = 0;
      for (int i = 1; i <= 20 && cnt == 0; i++) begin
         @(negedge CLK);
         if (!(&m_cs1) || !(&m_cs2)) cnt = i;
      end
   endtask
   task automatic idle_check(input string nm);
      chk({nm, " idle"}, {m_dtack, m_ior, m_iow, &m_cs1, &m_cs2, m_rom, m_doe}, 7'b0111100);
   endtask
   task automatic do_cycle(input int k, input vec_t v);
      int ior_w, iow_w, lat, fcs, fst, dout;
      logic [1:0] cs1, cs2;
      logic rom, doe;
      ior_w = 0; iow_w = 0; lat = 0; fcs = 0; fst = 0; dout = 0;
      cs1 = 2'b11; cs2 = 2'b11; rom = 0; doe = 0;
      ide_enable = v.en;
      drive(v.a, v.rw, v.din);
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         @(negedge CLK);
         if (!m_ior) ior_w++;
         if (!m_iow) iow_w++;
         if ((!m_ior || !m_iow) && fst == 0) fst = i;
         if ((!(&m_cs1) || !(&m_cs2)) && fcs == 0) fcs = i;
         cs1 &= m_cs1;
         cs2 &= m_cs2;
         rom |= m_rom;
         if (m_doe && !doe) dout = m_dout;
         doe |= m_doe;
         if (m_dtack) lat = i;
      end
      chk($sformatf("v%0d dtack_lat", k), lat, v.lat);
      chk($sformatf("v%0d ior_w", k), ior_w, v.ior_w);
      chk($sformatf("v%0d iow_w", k), iow_w, v.iow_w);
      chk($sformatf("v%0d cs1", k), cs1, v.cs1);
      chk($sformatf("v%0d cs2", k), cs2, v.cs2);
      chk($sformatf("v%0d romen", k), rom, v.rom);
      chk($sformatf("v%0d dout_oe", k), doe, v.doe);
      if (v.doe) chk($sformatf("v%0d dout", k), dout, v.dout);
      if (v.ior_w + v.iow_w > 0) begin
         chk($sformatf("v%0d cs_first", k), fcs, 1);
         chk($sformatf("v%0d strobe_first", k), fst, 2);
      end
      release_bus();
      @(negedge CLK);
      idle_check($sformatf("v%0d release", k));
      ide_enable = 1;
      repeat (4) @(negedge CLK);
   endtask
   initial begin
      vt[0]  = '{24'h004000, 1, 0, 1, 3, 0,  2'b10, 2'b11, 0, 6,      0, 0};
      vt[1]  = '{24'h005000, 0, 0, 1, 0, 3,  2'b11, 2'b10, 0, 6,      0, 0};
      vt[2]  = '{24'h008000, 1, 0, 1, 3, 0,  2'b01, 2'b11, 0, 6,      0, 0};
      vt[3]  = '{24'h000000, 1, 0, 1, 0, 0,  2'b11, 2'b11, 1, 3,      0, 0};
      vt[4]  = '{24'h00C000, 1, 0, 1, 0, 0,  2'b11, 2'b11, 0, 2,      1, 3};
      vt[5]  = '{24'h00C004, 0, 6, 1, 0, 0,  2'b11, 2'b11, 0, 2,      0, 0};
      vt[6]  = '{24'h009000, 0, 0, 1, 0, W6, 2'b11, 2'b01, 0, W6 + 3, 0, 0};
      vt[7]  = '{24'h004000, 1, 0, 1, 3, 0,  2'b10, 2'b11, 0, 6,      0, 0};
      vt[8]  = '{24'h00C004, 1, 0, 1, 0, 0,  2'b11, 2'b11, 0, 2,      1, W6};
      vt[9]  = '{24'h00C004, 0, 0, 1, 0, 0,  2'b11, 2'b11, 0, 2,      0, 0};
      vt[10] = '{24'h00C004, 1, 0, 1, 0, 0,  2'b11, 2'b11, 0, 2,      1, W0};
      vt[11] = '{24'h004000, 1, 0, 0, 0, 0,  2'b11, 2'b11, 0, 2,      0, 0};
      repeat (3) @(negedge CLK);
      idle_check("reset");
      chk("reset dout", dout0, 0);
      RESET_n = 1;
      repeat (2) @(negedge CLK);
      for (int k = 0; k < 12; k++) do_cycle(k, vt[k]);
      // recovery hold-off: a new AS_n right after release is accepted on the first IDLE clock
      drive(24'h004000, 1, 0);
      wait_dtack(n);
      chk("hs read dtack_lat", n, 6);
      release_bus();
      @(negedge CLK);
      chk("hs dtack drop", m_dtack, 0);
      drive(24'h004000, 1, 0);
      wait_cs(n);
      chk("recover holdoff", n, 3);
      wait_dtack(n);
      chk("b2b dtack_lat", n, 5);
      release_bus();
      repeat (5) @(negedge CLK);
      // abort on the second strobe clock
      drive(24'h004000, 1, 0);
      repeat (3) @(negedge CLK);
      chk("abort ior before", m_ior, 0);
      release_bus();
      @(negedge CLK);
      idle_check("abort");
      drive(24'h004000, 1, 0);
      wait_cs(n);
      chk("abort recover holdoff", n, 3);
      wait_dtack(n);
      chk("abort b2b dtack_lat", n, 5);
      release_bus();
      repeat (5) @(negedge CLK);
      // no accept without ide_access
      ide_access = 0;
      drive(24'h004000, 1, 0);
      wait_dtack(n);
      chk("no access dtack", n, 0);
      chk("no access cs", {&m_cs1, &m_cs2}, 2'b11);
      release_bus();
      ide_access = 1;
      repeat (2) @(negedge CLK);
      // single-channel build treats channel 1 as a null cycle
      mon = 1;
      do_cycle(20, '{24'h008000, 1, 0, 1, 0, 0, 2'b11, 2'b11, 0, 2, 0, 0});
      mon = 0;
      repeat (2) @(negedge CLK);
      // asynchronous reset in the middle of a strobe
      drive(24'h004000, 1, 0);
      repeat (3) @(negedge CLK);
      chk("rst mid ior before", m_ior, 0);
      RESET_n = 0;
      #1;
      idle_check("rst mid");
      release_bus();
      @(negedge CLK);
      RESET_n = 1;
      repeat (2) @(negedge CLK);
      do_cycle(30, '{24'h00C004, 1, 0, 1, 0, 0, 2'b11, 2'b11, 0, 2, 1, 3});
      do_cycle(31, vt[0]);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
